slot_scheduler: RTL and testbench

//  Sequences jobs held in NUM_SLOTS descriptor slots through a shared DMA engine and one compute kernel.

---
 rtl/slot_scheduler_if.sv | 51 +++++
 rtl/slot_scheduler.sv | 176 +++++++++++++++++
 tb/tb_slot_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_scheduler_if.sv
// Control bundle between the slot scheduler, the descriptor slot bank, the DMA engine and the kernel.
// master = scheduler side, slave = environment side.
interface slot_scheduler_if #(
    parameter int NUM_SLOTS     = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int SIZE_WIDTH    = 26,
    parameter int STATUS_WIDTH  = 2,
    parameter int PROFILE_WIDTH = 32,
    parameter int MSK_WIDTH     = 8
);
    logic                              en;
    logic [NUM_SLOTS*STATUS_WIDTH-1:0] slot_status;
    logic [IDX_WIDTH-1:0]              slot_idx;
    logic [ADDR_WIDTH-1:0]             sel_src_addr;
    logic [SIZE_WIDTH-1:0]             sel_src_size;
    logic [ADDR_WIDTH-1:0]             sel_des_addr;
    logic [SIZE_WIDTH-1:0]             sel_des_size;
    logic [MSK_WIDTH-1:0]              sel_ld_mask;
    logic [MSK_WIDTH-1:0]              sel_st_mask;
    logic                              dma_valid;
    logic                              dma_ready;
    logic                              dma_dir;
    logic [ADDR_WIDTH-1:0]             dma_addr;
    logic [SIZE_WIDTH-1:0]             dma_size;
    logic [MSK_WIDTH-1:0]              dma_mask;
    logic                              dma_done;
    logic                              krn_start;
    logic                              krn_done;
    logic [STATUS_WIDTH-1:0]           wr_status;
    logic                              set_status;
    logic [PROFILE_WIDTH-1:0]          wr_profile;
    logic                              set_profile;
    logic [MSK_WIDTH-1:0]              wr_intr_ack;
    logic                              set_intr_ack;
    logic                              busy;

    modport master (
        input  en, slot_status, sel_src_addr, sel_src_size, sel_des_addr, sel_des_size,
               sel_ld_mask, sel_st_mask, dma_ready, dma_done, krn_done,
        output slot_idx, dma_valid, dma_dir, dma_addr, dma_size, dma_mask, krn_start,
               wr_status, set_status, wr_profile, set_profile, wr_intr_ack, set_intr_ack, busy
    );

    modport slave (
        output en, slot_status, sel_src_addr, sel_src_size, sel_des_addr, sel_des_size,
               sel_ld_mask, sel_st_mask, dma_ready, dma_done, krn_done,
        input  slot_idx, dma_valid, dma_dir, dma_addr, dma_size, dma_mask, krn_start,
               wr_status, set_status, wr_profile, set_profile, wr_intr_ack, set_intr_ack, busy
    );
endinterface

// File: rtl/slot_scheduler.sv
// Round-robin job sequencer: claims a READY slot, runs load DMA -> kernel -> store DMA,
// then writes DONE status, the cycle profile and the store-interrupt ack mask back to the slot.
module slot_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int SIZE_WIDTH    = 26,
    parameter int STATUS_WIDTH  = 2,
    parameter int PROFILE_WIDTH = 32,
    parameter int MSK_WIDTH     = 8
) (
    input logic              clk,
    input logic              reset,
    slot_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLAIM, S_LD_REQ, S_LD_WAIT, S_KRN, S_ST_REQ, S_ST_WAIT, S_FIN
    } state_e;

    localparam logic [STATUS_WIDTH-1:0] ST_READY = STATUS_WIDTH'(1);
    localparam logic [STATUS_WIDTH-1:0] ST_BUSY  = STATUS_WIDTH'(2);
    localparam logic [STATUS_WIDTH-1:0] ST_DONE  = STATUS_WIDTH'(3);

    state_e                   state_q;
    logic [IDX_WIDTH-1:0]     slot_idx_q, rr_q;
    logic [ADDR_WIDTH-1:0]    des_addr_q, dma_addr_q;
    logic [SIZE_WIDTH-1:0]    des_size_q, dma_size_q;
    logic [MSK_WIDTH-1:0]     st_mask_q, dma_mask_q, wr_intr_ack_q;
    logic [PROFILE_WIDTH-1:0] prof_q, prof_d, wr_profile_q;
    logic [STATUS_WIDTH-1:0]  wr_status_q;
    logic                     dma_valid_q, dma_dir_q, krn_start_q;
    logic                     set_status_q, set_profile_q, set_intr_ack_q;
    logic                     any_ready, go_fin;
    logic [IDX_WIDTH-1:0]     pick_idx;

    function automatic logic [PROFILE_WIDTH-1:0] sat_inc(input logic [PROFILE_WIDTH-1:0] v);
        return (&v) ? v : v + PROFILE_WIDTH'(1);
    endfunction

    // Descending scan so the slot nearest after the rr pointer wins.
    always_comb begin
        any_ready = 1'b0;
        pick_idx  = rr_q;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            if (bus.slot_status[((int'(rr_q) + k) % NUM_SLOTS) * STATUS_WIDTH +: STATUS_WIDTH] == ST_READY) begin
                any_ready = 1'b1;
                pick_idx  = IDX_WIDTH'((int'(rr_q) + k) % NUM_SLOTS);
            end
        end
    end

    assign prof_d = sat_inc(prof_q);
    assign go_fin = (state_q == S_KRN && bus.krn_done && des_size_q == '0) ||
                    (state_q == S_ST_WAIT && bus.dma_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            slot_idx_q     <= '0;
            rr_q           <= IDX_WIDTH'(NUM_SLOTS - 1);
            des_addr_q     <= '0;
            des_size_q     <= '0;
            st_mask_q      <= '0;
            prof_q         <= '0;
            dma_valid_q    <= 1'b0;
            dma_dir_q      <= 1'b0;
            dma_addr_q     <= '0;
            dma_size_q     <= '0;
            dma_mask_q     <= '0;
            krn_start_q    <= 1'b0;
            wr_status_q    <= '0;
            set_status_q   <= 1'b0;
            wr_profile_q   <= '0;
            set_profile_q  <= 1'b0;
            wr_intr_ack_q  <= '0;
            set_intr_ack_q <= 1'b0;
        end else begin
            set_status_q   <= 1'b0;
            set_profile_q  <= 1'b0;
            set_intr_ack_q <= 1'b0;
            krn_start_q    <= 1'b0;
            if (state_q != S_IDLE) prof_q <= prof_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.en && any_ready) begin
                        slot_idx_q   <= pick_idx;
                        state_q      <= S_CLAIM;
                        set_status_q <= 1'b1;
                        wr_status_q  <= ST_BUSY;
                        prof_q       <= '0;
                    end
                end
                S_CLAIM: begin
                    des_addr_q <= bus.sel_des_addr;
                    des_size_q <= bus.sel_des_size;
                    st_mask_q  <= bus.sel_st_mask;
                    if (bus.sel_src_size != '0) begin
                        state_q     <= S_LD_REQ;
                        dma_valid_q <= 1'b1;
                        dma_dir_q   <= 1'b0;
                        dma_addr_q  <= bus.sel_src_addr;
                        dma_size_q  <= bus.sel_src_size;
                        dma_mask_q  <= bus.sel_ld_mask;
                    end else begin
                        state_q     <= S_KRN;
                        krn_start_q <= 1'b1;
                    end
                end
                S_LD_REQ: begin
                    if (bus.dma_ready) begin
                        dma_valid_q <= 1'b0;
                        state_q     <= S_LD_WAIT;
                    end
                end
                S_LD_WAIT: begin
                    if (bus.dma_done) begin
                        state_q     <= S_KRN;
                        krn_start_q <= 1'b1;
                    end
                end
                S_KRN: begin
                    if (bus.krn_done) begin
                        if (des_size_q != '0) begin
                            state_q     <= S_ST_REQ;
                            dma_valid_q <= 1'b1;
                            dma_dir_q   <= 1'b1;
                            dma_addr_q  <= des_addr_q;
                            dma_size_q  <= des_size_q;
                            dma_mask_q  <= st_mask_q;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_ST_REQ: begin
                    if (bus.dma_ready) begin
                        dma_valid_q <= 1'b0;
                        state_q     <= S_ST_WAIT;
                    end
                end
                S_ST_WAIT: begin
                    if (bus.dma_done) state_q <= S_FIN;
                end
                S_FIN: begin
                    rr_q    <= slot_idx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Write-back strobes are registered so they are valid during the FIN cycle itself.
            if (go_fin) begin
                set_status_q   <= 1'b1;
                wr_status_q    <= ST_DONE;
                set_profile_q  <= 1'b1;
                wr_profile_q   <= prof_d;
                set_intr_ack_q <= 1'b1;
                wr_intr_ack_q  <= st_mask_q;
            end
        end
    end

    assign bus.slot_idx     = slot_idx_q;
    assign bus.dma_valid    = dma_valid_q;
    assign bus.dma_dir      = dma_dir_q;
    assign bus.dma_addr     = dma_addr_q;
    assign bus.dma_size     = dma_size_q;
    assign bus.dma_mask     = dma_mask_q;
    assign bus.krn_start    = krn_start_q;
    assign bus.wr_status    = wr_status_q;
    assign bus.set_status   = set_status_q;
    assign bus.wr_profile   = wr_profile_q;
    assign bus.set_profile  = set_profile_q;
    assign bus.wr_intr_ack  = wr_intr_ack_q;
    assign bus.set_intr_ack = set_intr_ack_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_slot_scheduler.sv
// Directed bench for slot_scheduler: table of job scenarios plus hand-written stall, en-drop
// and mid-job reset sequences, with cycle-based slot bank, DMA and kernel models.
module tb_slot_scheduler;
    localparam int NS = 4, IW = 2, AW = 32, SZW = 26, STW = 2, PW = 32, MW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    slot_scheduler_if #(.NUM_SLOTS(NS), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SZW),
                        .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW), .MSK_WIDTH(MW)) bus ();

    slot_scheduler #(.NUM_SLOTS(NS), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SZW),
                     .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW), .MSK_WIDTH(MW)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    typedef struct packed {
        logic           dir;
        logic [AW-1:0]  addr;
        logic [SZW-1:0] size;
        logic [MW-1:0]  mask;
    } cmd_t;

    typedef struct {
        logic [3:0] rdy;
        bit         en;
        bit         src_nz;
        bit         des_nz;
        int         klat;
        int         njobs;
        logic [7:0] order;
        int         prof;
    } vec_t;

    int n_assert = 0, n_fail = 0;

    logic [STW-1:0] stat[NS];
    logic [AW-1:0]  s_addr[NS], d_addr[NS];
    logic [SZW-1:0] s_size[NS], d_size[NS];
    logic [MW-1:0]  l_mask[NS], s_mask[NS];

    int   cyc = 0, dma_done_at = -1, krn_done_at = -1, krn_lat = 0, krn_seen = 0;
    int   dma_lat = 3;
    bit   ready_block = 1'b0;
    cmd_t cmds[$];
    int   claims[$], claim_cyc[$], fin_cyc[$], fin_slot[$];
    logic [PW-1:0] profs[$];
    logic [MW-1:0] acks[$];
    bit   fin_ok[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_bank();
        int idx;
        for (int i = 0; i < NS; i++) bus.slot_status[i*STW +: STW] = stat[i];
        idx = int'(bus.slot_idx);
        bus.sel_src_addr = s_addr[idx];
        bus.sel_src_size = s_size[idx];
        bus.sel_des_addr = d_addr[idx];
        bus.sel_des_size = d_size[idx];
        bus.sel_ld_mask  = l_mask[idx];
        bus.sel_st_mask  = s_mask[idx];
    endtask

    // One clock: observe the DUT's outputs for the new cycle, then drive this cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.set_status) begin
            stat[bus.slot_idx] = bus.wr_status;
            if (bus.wr_status == 2'd2) begin
                claims.push_back(int'(bus.slot_idx));
                claim_cyc.push_back(cyc);
            end
        end
        if (bus.set_profile) begin
            profs.push_back(bus.wr_profile);
            acks.push_back(bus.wr_intr_ack);
            fin_ok.push_back(bus.set_status && bus.wr_status == 2'd3 && bus.set_intr_ack);
            fin_cyc.push_back(cyc);
            fin_slot.push_back(int'(bus.slot_idx));
        end
        bus.dma_done  = (cyc == dma_done_at);
        bus.krn_done  = (cyc == krn_done_at);
        bus.dma_ready = !ready_block;
        if (bus.dma_valid && bus.dma_ready) begin
            cmds.push_back('{bus.dma_dir, bus.dma_addr, bus.dma_size, bus.dma_mask});
            dma_done_at = cyc + dma_lat;
        end
        if (bus.krn_start) begin
            krn_seen++;
            krn_done_at = cyc + krn_lat;
            if (krn_lat == 0) bus.krn_done = 1'b1;
        end
        drive_bank();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dma_done_at = -1; krn_done_at = -1; ready_block = 1'b0; krn_seen = 0;
        step();
        step();
        reset = 1'b0;
        cmds.delete(); claims.delete(); claim_cyc.delete(); fin_cyc.delete();
        fin_slot.delete(); profs.delete(); acks.delete(); fin_ok.delete();
    endtask

    task automatic setup_slots(input logic [3:0] rdy, input bit src_nz, input bit des_nz);
        for (int i = 0; i < NS; i++) begin
            stat[i]   = rdy[i] ? 2'd1 : 2'd0;
            s_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
            s_size[i] = src_nz ? SZW'(64 * (i + 1)) : '0;
            d_addr[i] = 32'h2000_0000 + 32'(i) * 32'h40;
            d_size[i] = des_nz ? SZW'(32 * (i + 1)) : '0;
            l_mask[i] = 8'h50 | 8'(i);
            s_mask[i] = 8'hA0 + 8'(i * 3);
        end
        drive_bank();
    endtask

    task automatic wait_fins(input int n, input int lim, input string nm);
        int g = 0;
        while (profs.size() < n && g < lim) begin step(); g++; end
        check({nm, "_timeout"}, profs.size() >= n, 1'b1);
    endtask

    vec_t vecs[6];

    initial begin
        cmd_t exp_cmds[$];
        int   g, o, strobes;
        logic [AW-1:0] a0;
        logic [SZW-1:0] z0;

        // {ready mask, en, src!=0, des!=0, kernel latency, jobs, slot order (2b each), profile}
        vecs[0] = '{4'b0100, 1'b1, 1'b1, 1'b1, 5, 1, 8'h02, 15};
        vecs[1] = '{4'b1011, 1'b1, 1'b1, 1'b1, 0, 3, 8'h34, 10};
        vecs[2] = '{4'b0010, 1'b1, 1'b0, 1'b0, 0, 1, 8'h01, 2};
        vecs[3] = '{4'b0001, 1'b1, 1'b1, 1'b0, 5, 1, 8'h00, 11};
        vecs[4] = '{4'b1000, 1'b1, 1'b0, 1'b1, 0, 1, 8'h03, 6};
        vecs[5] = '{4'b1111, 1'b0, 1'b1, 1'b1, 0, 0, 8'h00, 0};

        reset = 1'b1;
        bus.en = 1'b0; bus.dma_ready = 1'b0; bus.dma_done = 1'b0; bus.krn_done = 1'b0;
        setup_slots(4'b0000, 1'b0, 1'b0);
        do_reset();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_slot_idx", bus.slot_idx, 2'd0);
        check("rst_dma_valid", bus.dma_valid, 1'b0);
        check("rst_strobes", {bus.set_status, bus.set_profile, bus.set_intr_ack, bus.krn_start}, 4'b0);
        check("rst_data", {bus.dma_addr, bus.wr_profile, bus.wr_intr_ack}, '0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            krn_lat = vecs[s].klat;
            setup_slots(vecs[s].rdy, vecs[s].src_nz, vecs[s].des_nz);
            bus.en = vecs[s].en;
            wait_fins(vecs[s].njobs, 400, $sformatf("v%0d", s));
            repeat (20) step();
            check($sformatf("v%0d_jobs", s), claims.size(), vecs[s].njobs);
            check($sformatf("v%0d_fins", s), profs.size(), vecs[s].njobs);
            check($sformatf("v%0d_busy_end", s), bus.busy, 1'b0);
            exp_cmds.delete();
            for (int j = 0; j < vecs[s].njobs; j++) begin
                o = int'(vecs[s].order[2*j +: 2]);
                if (vecs[s].src_nz) exp_cmds.push_back('{1'b0, s_addr[o], s_size[o], l_mask[o]});
                if (vecs[s].des_nz) exp_cmds.push_back('{1'b1, d_addr[o], d_size[o], s_mask[o]});
                if (j < claims.size() && j < profs.size()) begin
                    check($sformatf("v%0d_j%0d_slot", s, j), claims[j], o);
                    check($sformatf("v%0d_j%0d_fin_slot", s, j), fin_slot[j], o);
                    check($sformatf("v%0d_j%0d_profile", s, j), profs[j], vecs[s].prof);
                    check($sformatf("v%0d_j%0d_fin_latency", s, j), fin_cyc[j] - claim_cyc[j], vecs[s].prof);
                    check($sformatf("v%0d_j%0d_ack", s, j), acks[j], s_mask[o]);
                    check($sformatf("v%0d_j%0d_fin_strobes", s, j), fin_ok[j], 1'b1);
                    check($sformatf("v%0d_j%0d_status", s, j), stat[o], 2'd3);
                end
            end
            check($sformatf("v%0d_ncmds", s), cmds.size(), exp_cmds.size());
            for (int k = 0; k < exp_cmds.size(); k++)
                if (k < cmds.size()) check($sformatf("v%0d_cmd%0d", s, k), cmds[k], exp_cmds[k]);
        end

        // dma_ready low for 10 LD_REQ cycles: command must hold, accepted on the 11th.
        do_reset();
        krn_lat = 0;
        setup_slots(4'b0001, 1'b1, 1'b0);
        ready_block = 1'b1;
        bus.en = 1'b1;
        g = 0;
        while (!bus.dma_valid && g < 20) begin step(); g++; end
        check("stall_valid_seen", bus.dma_valid, 1'b1);
        a0 = s_addr[0]; z0 = s_size[0];
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_c%0d_cmd", i), {bus.dma_valid, bus.dma_dir, bus.dma_addr, bus.dma_size},
                  {1'b1, 1'b0, a0, z0});
            if (i == 9) ready_block = 1'b0;
            step();
        end
        check("stall_c10_valid", bus.dma_valid, 1'b1);
        check("stall_c10_mask", bus.dma_mask, l_mask[0]);
        step();
        check("stall_accepted", {bus.dma_valid, 32'(cmds.size())}, {1'b0, 32'd1});
        wait_fins(1, 50, "stall");
        if (profs.size() > 0) check("stall_profile", profs[0], 32'd16);

        // en dropped during the kernel: job finishes, no new claim until en returns.
        do_reset();
        krn_lat = 5;
        setup_slots(4'b0001, 1'b1, 1'b1);
        bus.en = 1'b1;
        g = 0;
        while (krn_seen == 0 && g < 30) begin step(); g++; end
        check("endrop_krn_seen", krn_seen, 1);
        bus.en = 1'b0;
        stat[1] = 2'd1;
        drive_bank();
        wait_fins(1, 50, "endrop");
        if (profs.size() > 0) check("endrop_profile", profs[0], 32'd15);
        repeat (20) step();
        check("endrop_no_claim", claims.size(), 1);
        check("endrop_idle", bus.busy, 1'b0);
        bus.en = 1'b1;
        g = 0;
        while (claims.size() < 2 && g < 10) begin step(); g++; end
        check("endrop_reclaim", claims.size(), 2);
        if (claims.size() > 1) check("endrop_reclaim_slot", claims[1], 1);

        // Reset while waiting for the store DMA: job abandoned, late dma_done ignored.
        do_reset();
        krn_lat = 0;
        setup_slots(4'b1000, 1'b1, 1'b1);
        bus.en = 1'b1;
        g = 0;
        while (cmds.size() < 2 && g < 60) begin step(); g++; end
        check("rstjob_store_issued", cmds.size(), 2);
        step();
        check("rstjob_in_st_wait", {bus.busy, bus.dma_valid}, 2'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstjob_idle", {bus.busy, bus.dma_valid, bus.slot_idx}, {1'b0, 1'b0, 2'd0});
        check("rstjob_no_strobe", {bus.set_status, bus.set_profile, bus.set_intr_ack}, 3'b0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            strobes += int'(bus.set_status) + int'(bus.set_profile) + int'(bus.set_intr_ack) + int'(bus.busy);
        end
        check("rstjob_done_ignored", strobes, 0);
        check("rstjob_slot_busy", stat[3], 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
